// File: rtl/relay_seq_pkg.sv
// Shared types and opcode-class decode for the relay sequencer.
package relay_seq_pkg;

   typedef enum logic [2:0] {
      CLS_MOV8  = 3'd0,
      CLS_ALU   = 3'd1,
      CLS_SETAB = 3'd2,
      CLS_LDST  = 3'd3,
      CLS_MISC  = 3'd4,
      CLS_INC   = 3'd5,
      CLS_GOTO  = 3'd6
   } instr_class_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } seq_state_t;

   // Map the top four opcode bits onto an instruction class.
   function automatic instr_class_t decode_class(input logic [3:0] op);
      instr_class_t cls;
      cls = CLS_MOV8;
      unique case (op[3:2])
         2'b00: cls = CLS_MOV8;
         2'b01: cls = CLS_SETAB;
         2'b11: cls = CLS_GOTO;
         default: begin
            unique case (op[1:0])
               2'b00:   cls = CLS_ALU;
               2'b01:   cls = CLS_LDST;
               2'b10:   cls = CLS_MISC;
               default: cls = CLS_INC;
            endcase
         end
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/relay_sequencer_param.sv
// Parametrised relay-computer step sequencer: common fetch, per-class
// sequence lengths, single-step, run gating at boundaries and HALT/continue.
module relay_sequencer_param
   import relay_seq_pkg::*;
#(
   parameter int unsigned CTRL_W      = 24,
   parameter int unsigned OPC_W       = 4,
   parameter int unsigned FETCH_STEPS = 4,
   parameter int unsigned LEN_MOV8    = 8,
   parameter int unsigned LEN_ALU     = 8,
   parameter int unsigned LEN_SETAB   = 8,
   parameter int unsigned LEN_LDST    = 12,
   parameter int unsigned LEN_MISC    = 12,
   parameter int unsigned LEN_INC     = 14,
   parameter int unsigned LEN_GOTO    = 24,
   parameter int unsigned STEP_W      = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [OPC_W-1:0]  instruction_bits,
   input  logic              halt_instr,
   input  logic              run,
   input  logic              cont,
   input  logic              step_mode,
   input  logic              step_req,
   output logic [CTRL_W-1:0] outputState,
   output logic [STEP_W-1:0] step_count,
   output logic [2:0]        instr_class,
   output logic              instr_done,
   output logic              halted
);

   localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(FETCH_STEPS - 1);

   // Parameter sanity: every class outlasts fetch and fits the control word.
   if (OPC_W < 4) begin : g_chk_opc
      $error("OPC_W must be at least 4");
   end
   if ((2 ** STEP_W) < CTRL_W) begin : g_chk_step
      $error("STEP_W too narrow for CTRL_W");
   end
   if (LEN_MOV8 <= FETCH_STEPS || LEN_ALU <= FETCH_STEPS || LEN_SETAB <= FETCH_STEPS ||
       LEN_LDST <= FETCH_STEPS || LEN_MISC <= FETCH_STEPS || LEN_INC <= FETCH_STEPS ||
       LEN_GOTO <= FETCH_STEPS) begin : g_chk_fetch
      $error("every LEN_* must exceed FETCH_STEPS");
   end
   if (LEN_MOV8 > CTRL_W || LEN_ALU > CTRL_W || LEN_SETAB > CTRL_W ||
       LEN_LDST > CTRL_W || LEN_MISC > CTRL_W || LEN_INC > CTRL_W ||
       LEN_GOTO > CTRL_W) begin : g_chk_ctrl
      $error("every LEN_* must be <= CTRL_W");
   end

   // Index of the final step for a class.
   function automatic logic [STEP_W-1:0] last_step(input instr_class_t c);
      logic [STEP_W-1:0] l;
      unique case (c)
         CLS_ALU:   l = STEP_W'(LEN_ALU - 1);
         CLS_SETAB: l = STEP_W'(LEN_SETAB - 1);
         CLS_LDST:  l = STEP_W'(LEN_LDST - 1);
         CLS_MISC:  l = STEP_W'(LEN_MISC - 1);
         CLS_INC:   l = STEP_W'(LEN_INC - 1);
         CLS_GOTO:  l = STEP_W'(LEN_GOTO - 1);
         default:   l = STEP_W'(LEN_MOV8 - 1);
      endcase
      return l;
   endfunction

   seq_state_t        state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   instr_class_t      class_q, class_d;
   logic              hflag_q, hflag_d;
   logic [CTRL_W-1:0] out_q, out_d;
   logic              done_q, done_d;
   logic              halted_q, halted_d;
   logic              adv;
   instr_class_t      dec_cls;

   assign adv     = !step_mode || step_req;
   assign dec_cls = decode_class(instruction_bits[OPC_W-1 -: 4]);

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      class_d = class_q;
      hflag_d = hflag_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
               step_d  = '0;
            end
         end
         RUN: begin
            if (adv) begin
               if (step_q == last_step(class_q)) begin
                  done_d = 1'b1;
                  step_d = '0;
                  if (hflag_q)   state_d = HALTED;
                  else if (!run) state_d = IDLE;
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
               if (step_q == FETCH_LAST) begin
                  class_d = dec_cls;
                  hflag_d = halt_instr && (dec_cls == CLS_MISC);
               end
            end
         end
         HALTED: begin
            step_d = '0;
            if (cont) begin
               state_d = RUN;
               hflag_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
         end
      endcase
      out_d    = (state_d == RUN) ? (CTRL_W'(1) << step_d) : '0;
      halted_d = (state_d == HALTED);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         step_q   <= '0;
         class_q  <= CLS_MOV8;
         hflag_q  <= 1'b0;
         out_q    <= '0;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         class_q  <= class_d;
         hflag_q  <= hflag_d;
         out_q    <= out_d;
         done_q   <= done_d;
         halted_q <= halted_d;
      end
   end

   assign outputState = out_q;
   assign step_count  = step_q;
   assign instr_class = class_q;
   assign instr_done  = done_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_relay_sequencer_param.sv
// Randomized and directed bench for relay_sequencer_param against an
// instruction-level reference model.
module tb_relay_sequencer_param;

   localparam int unsigned CTRL_W = 24;
   localparam int unsigned STEP_W = 5;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [3:0]        instruction_bits;
   logic              halt_instr, run, cont, step_mode, step_req;
   logic [CTRL_W-1:0] outputState;
   logic [STEP_W-1:0] step_count;
   logic [2:0]        instr_class;
   logic              instr_done, halted;

   always #5 clock = ~clock;

   relay_sequencer_param dut (
      .clock(clock), .reset_n(reset_n), .instruction_bits(instruction_bits),
      .halt_instr(halt_instr), .run(run), .cont(cont), .step_mode(step_mode),
      .step_req(step_req), .outputState(outputState), .step_count(step_count),
      .instr_class(instr_class), .instr_done(instr_done), .halted(halted)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n    = 0;

   // Reference model: mode 0 idle, 1 running, 2 halted.
   int cls_of_op [16] = '{0,0,0,0, 2,2,2,2, 1,3,4,5, 6,6,6,6};
   int len_of_cls[7]  = '{8, 8, 8, 12, 12, 14, 24};
   int m_mode, m_step, m_cls, m_done;
   bit m_hflag;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_step = 0; m_cls = 0; m_hflag = 0; m_done = 0;
   endfunction

   function automatic void model_edge();
      bit fin;
      m_done = 0;
      if (m_mode == 0) begin
         if (run) begin m_mode = 1; m_step = 0; end
      end else if (m_mode == 2) begin
         m_step = 0;
         if (cont) begin m_mode = 1; m_hflag = 0; end
      end else if (!step_mode || step_req) begin
         fin = (m_step == len_of_cls[m_cls] - 1);
         if (fin) begin
            m_done = 1;
            m_step = 0;
            if (m_hflag)  m_mode = 2;
            else if (!run) m_mode = 0;
         end else begin
            m_step++;
            if (m_step == 4) begin
               m_cls   = cls_of_op[instruction_bits];
               m_hflag = halt_instr && (m_cls == 4);
            end
         end
      end
   endfunction

   task automatic compare_all();
      logic [31:0] eo;
      eo = (m_mode == 1) ? (32'h1 << m_step) : 32'h0;
      check("outputState", 32'(outputState), eo);
      check("step_count", 32'(step_count), 32'(m_step));
      check("instr_class", 32'(instr_class), 32'(m_cls));
      check("instr_done", 32'(instr_done), 32'(m_done));
      check("halted", 32'(halted), 32'(m_mode == 2));
   endtask

   // One clock: model follows the edge, DUT compared 1 time unit later.
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      cyc_n++;
      compare_all();
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!instr_done && n < 100);
      if (!instr_done) check({tag, "_timeout"}, 32'(n), 32'd0);
   endtask

   task automatic wait_step(input int s);
      int n;
      n = 0;
      while (int'(step_count) != s && n < 100) begin
         tick();
         n++;
      end
      if (int'(step_count) != s) check("wait_step_timeout", 32'(step_count), 32'(s));
   endtask

   initial begin
      int n;
      logic [3:0] ops [7] = '{4'b0000, 4'b1000, 4'b0100, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
      int exp_len[7] = '{8, 8, 8, 12, 12, 14, 24};

      reset_n = 1'b0; instruction_bits = 4'b0000; halt_instr = 0; run = 0;
      cont = 0; step_mode = 0; step_req = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      compare_all();
      reset_n = 1'b1;
      tick();

      // Per-class lengths back to back
      run = 1;
      tick();
      for (int i = 0; i < 7; i++) begin
         instruction_bits = ops[i];
         if (i == 6) run = 0;
         wait_done("len", n);
         check($sformatf("len_op%0b", ops[i]), 32'(n), 32'(exp_len[i]));
      end
      tick();
      check("idle_after_goto", 32'(outputState), 32'h0);

      // Class latched at end of fetch; later opcode changes are ignored
      instruction_bits = 4'b1011; run = 1;
      tick();
      wait_step(5);
      instruction_bits = 4'b0000;
      wait_done("latch_inc", n);
      check("latch_inc_len", 32'(n + 5), 32'd14);
      run = 0;
      wait_done("latch_mov", n);
      check("latch_mov_len", 32'(n), 32'd8);
      tick();

      // Single-step mode
      step_mode = 1; run = 1; instruction_bits = 4'b0000;
      tick();
      run = 0;
      n = 0;
      for (int p = 0; p < 8; p++) begin
         step_req = 0; tick(); tick();
         if (instr_done) n++;
         step_req = 1; tick();
         if (instr_done) n++;
      end
      step_req = 0;
      check("single_step_done_count", 32'(n), 32'd1);
      step_mode = 0;
      tick();

      // Halt and continue
      instruction_bits = 4'b1010; halt_instr = 1; run = 1;
      tick();
      wait_done("halt", n);
      check("halt_len", 32'(n), 32'd12);
      repeat (20) tick();
      check("halted_hold", 32'(halted), 32'd1);
      halt_instr = 0; cont = 1;
      tick();
      cont = 0;
      check("cont_resume", 32'(outputState), 32'h1);
      run = 0;
      wait_done("after_cont", n);
      tick();

      // Run dropped mid-LDST finishes the instruction
      instruction_bits = 4'b1001; run = 1;
      tick();
      wait_step(2);
      run = 0;
      wait_done("rundrop", n);
      check("rundrop_len", 32'(n + 2), 32'd12);
      repeat (3) tick();
      check("rundrop_idle", 32'(outputState), 32'h0);

      // Asynchronous reset mid-instruction
      instruction_bits = 4'b1100; run = 1;
      tick();
      wait_step(6);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_out", 32'(outputState), 32'h0);
      check("async_rst_step", 32'(step_count), 32'h0);
      cont = 1;
      @(posedge clock);
      #1;
      compare_all();
      cont = 0;
      reset_n = 1'b1; run = 1;
      tick();
      check("rst_release_out", 32'(outputState), 32'h1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 60 == 0) step_mode = ($urandom_range(0, 2) == 0);
         run              = ($urandom_range(0, 7) != 0);
         instruction_bits = 4'($urandom_range(0, 15));
         halt_instr       = ($urandom_range(0, 3) == 0);
         cont             = ($urandom_range(0, 15) == 0);
         step_req         = ($urandom_range(0, 1) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
